// File: rtl/ibex_pext_alu_pkg.sv
// Shared types for the packed-SIMD (Zpn subset) ALU: lane signedness, operation
// encodings and lane counts for the fixed 32-bit datapath.
package ibex_pkg_pext;

   localparam int unsigned NUM_LANES8  = 4;
   localparam int unsigned NUM_LANES16 = 2;

   typedef enum logic [1:0] {
      S8,
      U8,
      S16,
      U16
   } signed_type_e;

   // Encodings 30 and 31 are left undefined and produce a zero result.
   typedef enum logic [4:0] {
      ZPN_ADD8,      ZPN_ADD16,
      ZPN_SUB8,      ZPN_SUB16,
      ZPN_RADD8,     ZPN_RADD16,
      ZPN_RSUB8,     ZPN_RSUB16,
      ZPN_KADD8,     ZPN_KADD16,
      ZPN_KSUB8,     ZPN_KSUB16,
      ZPN_SLL8,      ZPN_SLL16,
      ZPN_SRL8,      ZPN_SRL16,
      ZPN_CMPEQ8,    ZPN_CMPEQ16,
      ZPN_SLT8,      ZPN_SLT16,
      ZPN_ZUNPKD810, ZPN_ZUNPKD820, ZPN_ZUNPKD830, ZPN_ZUNPKD831, ZPN_ZUNPKD832,
      ZPN_SUNPKD810, ZPN_SUNPKD820, ZPN_SUNPKD830, ZPN_SUNPKD831, ZPN_SUNPKD832
   } zpn_op_e;

endpackage

// File: rtl/ibex_pext_alu_lane16.sv
// 16-bit lane add/sub with halving and saturation; split_i runs it as two
// independent 8-bit lanes with no carry between them.
module ibex_pext_lane16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        split_i,
   input  logic        signed_i,
   input  logic        sat_i,
   input  logic        halve_i,
   input  logic        sub_i,
   output logic [15:0] result_o
);

   // A byte lane is left-aligned into the 16-bit datapath: overflow, carry and
   // the halving bit then land in the same places as for a full 16-bit lane.
   function automatic logic [15:0] core(input logic [15:0] a, input logic [15:0] b,
                                        input logic sgn, input logic sat,
                                        input logic halve, input logic sub);
      logic [16:0] ea, eb, s;
      ea = {sgn & a[15], a};
      eb = {sgn & b[15], b};
      s  = sub ? (ea - eb) : (ea + eb);
      if (halve)                              core = s[16:1];
      else if (sat && sgn && (s[16] != s[15])) core = s[16] ? 16'h8000 : 16'h7fff;
      else if (sat && !sgn && s[16])          core = sub ? 16'h0000 : 16'hffff;
      else                                    core = s[15:0];
   endfunction

   logic [15:0] full_res, hi_res, lo_res;
   logic        unused_low_bits;

   assign full_res = core(a_i, b_i, signed_i, sat_i, halve_i, sub_i);
   assign hi_res   = core({a_i[15:8], 8'h00}, {b_i[15:8], 8'h00}, signed_i, sat_i, halve_i, sub_i);
   assign lo_res   = core({a_i[7:0], 8'h00}, {b_i[7:0], 8'h00}, signed_i, sat_i, halve_i, sub_i);

   assign unused_low_bits = ^{hi_res[7:0], lo_res[7:0]};
   assign result_o = split_i ? {hi_res[15:8], lo_res[15:8]} : full_res;

endmodule

// File: rtl/ibex_pext_alu.sv
// Packed-SIMD ALU for the Zpn subset: 8/16-bit lane arithmetic, shifts, compares
// and byte unpacks, with a single registered result stage.
module ibex_pext_alu
   import ibex_pkg_pext::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [31:0]  operand_a_i,
   input  logic [31:0]  operand_b_i,
   input  logic         enable_i,
   input  signed_type_e signed_operands_i,
   input  zpn_op_e      operator_i,
   output logic [31:0]  result_o
);

   logic [NUM_LANES8-1:0][7:0]   a8, b8;
   logic [NUM_LANES16-1:0][15:0] a16, b16, arith16;
   logic                         sgn, split, sub, sat, halve;
   logic [2:0]                   sh8;
   logic [3:0]                   sh16;
   logic [31:0]                  res_d;

   assign a8   = operand_a_i;
   assign b8   = operand_b_i;
   assign a16  = operand_a_i;
   assign b16  = operand_b_i;
   assign sh8  = operand_b_i[2:0];
   assign sh16 = operand_b_i[3:0];

   // Signedness ignores the width half of the encoding.
   assign sgn   = (signed_operands_i == S8) || (signed_operands_i == S16);
   assign split = operator_i inside {ZPN_ADD8, ZPN_SUB8, ZPN_RADD8, ZPN_RSUB8, ZPN_KADD8, ZPN_KSUB8};
   assign sub   = operator_i inside {ZPN_SUB8, ZPN_SUB16, ZPN_RSUB8, ZPN_RSUB16, ZPN_KSUB8, ZPN_KSUB16};
   assign halve = operator_i inside {ZPN_RADD8, ZPN_RADD16, ZPN_RSUB8, ZPN_RSUB16};
   assign sat   = operator_i inside {ZPN_KADD8, ZPN_KADD16, ZPN_KSUB8, ZPN_KSUB16};

   for (genvar g = 0; g < NUM_LANES16; g++) begin : g_lane
      ibex_pext_lane16 u_lane (
         .a_i      (a16[g]),
         .b_i      (b16[g]),
         .split_i  (split),
         .signed_i (sgn),
         .sat_i    (sat),
         .halve_i  (halve),
         .sub_i    (sub),
         .result_o (arith16[g])
      );
   end

   function automatic logic [31:0] unpk(input logic [31:0] a, input logic [1:0] x,
                                        input logic [1:0] y, input logic sext);
      logic [7:0] bx, by;
      bx = a[{x, 3'b000} +: 8];
      by = a[{y, 3'b000} +: 8];
      unpk = {{8{sext & bx[7]}}, bx, {8{sext & by[7]}}, by};
   endfunction

   always_comb begin
      res_d = '0;
      case (operator_i)
         ZPN_ADD8, ZPN_ADD16, ZPN_SUB8, ZPN_SUB16, ZPN_RADD8, ZPN_RADD16,
         ZPN_RSUB8, ZPN_RSUB16, ZPN_KADD8, ZPN_KADD16, ZPN_KSUB8, ZPN_KSUB16:
            res_d = arith16;
         ZPN_SLL8:  for (int i = 0; i < NUM_LANES8; i++)  res_d[8*i +: 8]   = a8[i] << sh8;
         ZPN_SLL16: for (int i = 0; i < NUM_LANES16; i++) res_d[16*i +: 16] = a16[i] << sh16;
         ZPN_SRL8:  for (int i = 0; i < NUM_LANES8; i++)
            res_d[8*i +: 8] = 8'($signed({sgn & a8[i][7], a8[i]}) >>> sh8);
         ZPN_SRL16: for (int i = 0; i < NUM_LANES16; i++)
            res_d[16*i +: 16] = 16'($signed({sgn & a16[i][15], a16[i]}) >>> sh16);
         ZPN_CMPEQ8:  for (int i = 0; i < NUM_LANES8; i++)  res_d[8*i +: 8]   = {8{a8[i] == b8[i]}};
         ZPN_CMPEQ16: for (int i = 0; i < NUM_LANES16; i++) res_d[16*i +: 16] = {16{a16[i] == b16[i]}};
         ZPN_SLT8: for (int i = 0; i < NUM_LANES8; i++)
            res_d[8*i +: 8] = {8{$signed({sgn & a8[i][7], a8[i]}) < $signed({sgn & b8[i][7], b8[i]})}};
         ZPN_SLT16: for (int i = 0; i < NUM_LANES16; i++)
            res_d[16*i +: 16] = {16{$signed({sgn & a16[i][15], a16[i]}) < $signed({sgn & b16[i][15], b16[i]})}};
         ZPN_ZUNPKD810: res_d = unpk(operand_a_i, 2'd1, 2'd0, 1'b0);
         ZPN_ZUNPKD820: res_d = unpk(operand_a_i, 2'd2, 2'd0, 1'b0);
         ZPN_ZUNPKD830: res_d = unpk(operand_a_i, 2'd3, 2'd0, 1'b0);
         ZPN_ZUNPKD831: res_d = unpk(operand_a_i, 2'd3, 2'd1, 1'b0);
         ZPN_ZUNPKD832: res_d = unpk(operand_a_i, 2'd3, 2'd2, 1'b0);
         ZPN_SUNPKD810: res_d = unpk(operand_a_i, 2'd1, 2'd0, 1'b1);
         ZPN_SUNPKD820: res_d = unpk(operand_a_i, 2'd2, 2'd0, 1'b1);
         ZPN_SUNPKD830: res_d = unpk(operand_a_i, 2'd3, 2'd0, 1'b1);
         ZPN_SUNPKD831: res_d = unpk(operand_a_i, 2'd3, 2'd1, 1'b1);
         ZPN_SUNPKD832: res_d = unpk(operand_a_i, 2'd3, 2'd2, 1'b1);
         default:       res_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       result_o <= '0;
      else if (enable_i) result_o <= res_d;
   end

endmodule

// File: tb/tb_ibex_pext_alu.sv
// Directed bench for ibex_pext_alu: lane-level reference model checked every
// cycle, plus hand-computed literal results for each vector.
module tb_ibex_pext_alu;
   import ibex_pkg_pext::*;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic [31:0]  operand_a_i = '0, operand_b_i = '0;
   logic         enable_i = 1'b0;
   signed_type_e signed_operands_i = U16;
   zpn_op_e      operator_i = ZPN_ADD8;
   logic [31:0]  result_o;

   int checks = 0, failures = 0;
   bit run = 1'b0;
   logic [31:0] exp_r = '0;

   ibex_pext_alu dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .enable_i(enable_i), .signed_operands_i(signed_operands_i), .operator_i(operator_i),
      .result_o(result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef enum {K_ADD, K_SUB, K_RADD, K_RSUB, K_KADD, K_KSUB, K_SLL, K_SRL, K_EQ, K_LT} kind_e;

   function automatic logic [31:0] model(zpn_op_e op, signed_type_e st, logic [31:0] a, logic [31:0] b);
      bit sg = (st == S8) || (st == S16);
      int w = 8, x = 0, y = 0, sh;
      bit is_unpk = 1'b0, sx = 1'b0;
      kind_e k = K_ADD;
      longint m, ua, ub, va, vb, lo, hi, res;
      logic [31:0] r = '0;
      logic [7:0] bx, by;
      case (op)
         ZPN_ADD8:   begin w = 8;  k = K_ADD;  end  ZPN_ADD16:   begin w = 16; k = K_ADD;  end
         ZPN_SUB8:   begin w = 8;  k = K_SUB;  end  ZPN_SUB16:   begin w = 16; k = K_SUB;  end
         ZPN_RADD8:  begin w = 8;  k = K_RADD; end  ZPN_RADD16:  begin w = 16; k = K_RADD; end
         ZPN_RSUB8:  begin w = 8;  k = K_RSUB; end  ZPN_RSUB16:  begin w = 16; k = K_RSUB; end
         ZPN_KADD8:  begin w = 8;  k = K_KADD; end  ZPN_KADD16:  begin w = 16; k = K_KADD; end
         ZPN_KSUB8:  begin w = 8;  k = K_KSUB; end  ZPN_KSUB16:  begin w = 16; k = K_KSUB; end
         ZPN_SLL8:   begin w = 8;  k = K_SLL;  end  ZPN_SLL16:   begin w = 16; k = K_SLL;  end
         ZPN_SRL8:   begin w = 8;  k = K_SRL;  end  ZPN_SRL16:   begin w = 16; k = K_SRL;  end
         ZPN_CMPEQ8: begin w = 8;  k = K_EQ;   end  ZPN_CMPEQ16: begin w = 16; k = K_EQ;   end
         ZPN_SLT8:   begin w = 8;  k = K_LT;   end  ZPN_SLT16:   begin w = 16; k = K_LT;   end
         ZPN_ZUNPKD810: begin is_unpk = 1; x = 1; y = 0; end
         ZPN_ZUNPKD820: begin is_unpk = 1; x = 2; y = 0; end
         ZPN_ZUNPKD830: begin is_unpk = 1; x = 3; y = 0; end
         ZPN_ZUNPKD831: begin is_unpk = 1; x = 3; y = 1; end
         ZPN_ZUNPKD832: begin is_unpk = 1; x = 3; y = 2; end
         ZPN_SUNPKD810: begin is_unpk = 1; sx = 1; x = 1; y = 0; end
         ZPN_SUNPKD820: begin is_unpk = 1; sx = 1; x = 2; y = 0; end
         ZPN_SUNPKD830: begin is_unpk = 1; sx = 1; x = 3; y = 0; end
         ZPN_SUNPKD831: begin is_unpk = 1; sx = 1; x = 3; y = 1; end
         ZPN_SUNPKD832: begin is_unpk = 1; sx = 1; x = 3; y = 2; end
         default: return 32'h0;
      endcase
      if (is_unpk) begin
         bx = a[8*x +: 8];
         by = a[8*y +: 8];
         r[31:16] = (sx && bx[7]) ? (16'hFF00 | 16'(bx)) : 16'(bx);
         r[15:0]  = (sx && by[7]) ? (16'hFF00 | 16'(by)) : 16'(by);
         return r;
      end
      m  = 64'sd1 << w;
      lo = sg ? -(m / 2) : 0;
      hi = sg ? (m / 2 - 1) : (m - 1);
      sh = (w == 8) ? int'(b[2:0]) : int'(b[3:0]);
      for (int i = 0; i < 32 / w; i++) begin
         ua = longint'((a >> (w * i))) & (m - 1);
         ub = longint'((b >> (w * i))) & (m - 1);
         va = (sg && ua >= m / 2) ? ua - m : ua;
         vb = (sg && ub >= m / 2) ? ub - m : ub;
         case (k)
            K_ADD:  res = va + vb;
            K_SUB:  res = va - vb;
            K_RADD: res = (va + vb) >>> 1;
            K_RSUB: res = (va - vb) >>> 1;
            K_KADD: begin res = va + vb; if (res > hi) res = hi; if (res < lo) res = lo; end
            K_KSUB: begin res = va - vb; if (res > hi) res = hi; if (res < lo) res = lo; end
            K_SLL:  res = ua << sh;
            K_SRL:  res = va >>> sh;
            K_EQ:   res = (ua == ub) ? -1 : 0;
            default: res = (va < vb) ? -1 : 0;
         endcase
         r = r | 32'((res & (m - 1)) << (w * i));
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%08h expected=%08h", nm, act, exp);
      end
   endtask

   always @(posedge clk_i)
      if (rst_ni && enable_i) exp_r = model(operator_i, signed_operands_i, operand_a_i, operand_b_i);
   always @(negedge rst_ni) exp_r = '0;
   always @(negedge clk_i)
      if (run) chk("model_cycle", result_o, exp_r);

   task automatic vec(input string nm, input zpn_op_e op, input signed_type_e st,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      operator_i = op; signed_operands_i = st; operand_a_i = a; operand_b_i = b; enable_i = 1'b1;
      chk({nm, "_model"}, model(op, st, a, b), exp);
      @(posedge clk_i); #1;
      chk(nm, result_o, exp);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1 chk("reset", result_o, 32'h0);
      rst_ni = 1'b1;
      run = 1'b1;
      vec("zunpkd810", ZPN_ZUNPKD810, U16, 32'h81267F83, 32'h00000002, 32'h007F0083);
      vec("sunpkd810", ZPN_SUNPKD810, U16, 32'h81267F83, 32'h00000002, 32'h007FFF83);
      vec("zunpkd832", ZPN_ZUNPKD832, U16, 32'h81267F83, 32'h00000002, 32'h00810026);
      vec("add16",     ZPN_ADD16,     U16, 32'h7FFF0001, 32'h00010001, 32'h80000002);
      vec("kadd16_s",  ZPN_KADD16,    S16, 32'h7FFF0001, 32'h00010001, 32'h7FFF0002);
      vec("kadd16_u",  ZPN_KADD16,    U16, 32'hFFFF0001, 32'h00020001, 32'hFFFF0002);
      vec("sub8",      ZPN_SUB8,      U8,  32'h00000000, 32'h01010101, 32'hFFFFFFFF);
      vec("radd8_s",   ZPN_RADD8,     S8,  32'h7F7F7F7F, 32'h01010101, 32'h40404040);
      vec("radd8_u",   ZPN_RADD8,     U8,  32'hFFFFFFFF, 32'h01010101, 32'h80808080);
      vec("srl16_s",   ZPN_SRL16,     S16, 32'h80000010, 32'h00000002, 32'hE0000004);
      vec("srl16_u",   ZPN_SRL16,     U16, 32'h80000010, 32'h00000002, 32'h20000004);
      vec("sll16",     ZPN_SLL16,     U16, 32'h80000010, 32'h00000002, 32'h00000040);
      vec("sll16_amt", ZPN_SLL16,     U16, 32'h80000010, 32'h00000012, 32'h00000040);
      vec("cmpeq8",    ZPN_CMPEQ8,    U8,  32'h05FF0300, 32'h05010300, 32'hFF00FFFF);
      vec("slt8_s",    ZPN_SLT8,      S8,  32'h05FF0300, 32'h05010300, 32'h00FF0000);
      vec("slt8_u",    ZPN_SLT8,      U8,  32'h05FF0300, 32'h05010300, 32'h00000000);
      vec("ksub8_u",   ZPN_KSUB8,     U8,  32'h10203040, 32'h20102050, 32'h00101000);
      vec("ksub16_s",  ZPN_KSUB16,    S16, 32'h80000005, 32'h00010007, 32'h8000FFFE);
      vec("rsub16_s",  ZPN_RSUB16,    S16, 32'h00008000, 32'h00010001, 32'hFFFFBFFF);
      vec("srl8_s",    ZPN_SRL8,      S8,  32'h80F00010, 32'h00000003, 32'hF0FE0002);
      vec("undef_op",  zpn_op_e'(5'd31), S8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      vec("sunpkd831", ZPN_SUNPKD831, S8,  32'h81267F83, 32'h00000000, 32'hFF81007F);
      // Hold: operands and operator change with the strobe low.
      enable_i = 1'b0;
      operator_i = ZPN_ADD16; operand_a_i = 32'h12345678; operand_b_i = 32'h11111111;
      repeat (2) @(posedge clk_i);
      #1 chk("hold", result_o, 32'hFF81007F);
      // Reset between edges while an operation is pending.
      enable_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1 chk("async_reset", result_o, 32'h0);
      @(negedge clk_i);
      @(posedge clk_i); #1;
      chk("reset_held", result_o, 32'h0);
      rst_ni = 1'b1;
      vec("after_rst", ZPN_ADD8, U8, 32'h01020304, 32'h10203040, 32'h11223344);
      @(negedge clk_i);
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibex_pext_alu.md
Name:
ibex_pext_alu

Overview:
- Packed-SIMD ALU implementing a subset of the RISC-V P-extension (Zpn) for the Ibex core.
- Operates on 32-bit operands as four 8-bit lanes or two 16-bit lanes: add/sub, halving, saturating, shift, compare and byte-unpack operations.
- Sits beside the base ALU in the execute stage. Result is registered, with 1-cycle latency.

Parameters:
- None. Datapath width is fixed at 32.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- operand_a_i  in  32  packed operand A.
- operand_b_i  in  32  packed operand B. For shifts, only the shift amount is used.
- enable_i  in  1  capture strobe; result register loads only when high.
- signed_operands_i  in  signed_type_e (2)  lane signedness: S8, U8, S16, U16.
- operator_i  in  zpn_op_e (5)  operation select.
- result_o  out  32  registered packed result.

Behaviour:
- Reset: result_o = 0 asynchronously while rst_ni is low. This also applies mid-operation: a pending result is discarded.
- Latency: combinational compute; result_o loads on the rising clk_i edge when enable_i=1.
- enable_i=0: result_o holds its value.
- Lane width comes from operator_i only.
- Signedness comes from signed_operands_i only: S8/S16 mean signed, U8/U16 mean unsigned. Its width encoding is ignored.
- Lane i always maps to bits [w*i+w-1 : w*i]. No carries cross lanes.
- Operations, with w = 8 or 16:
  - ADD8/ADD16: modular lane add.
  - SUB8/SUB16: modular lane subtract (a − b).
  - RADD8/RADD16: (a+b)>>1, computed at w+1 bits, no overflow. Signed → sign-extended; unsigned → zero-extended.
  - RSUB8/RSUB16: (a−b)>>1, computed at w+1 bits, same extension rule.
  - KADD8/KADD16: saturating add. Signed clamps to [−2^(w−1), 2^(w−1)−1]; unsigned clamps to [0, 2^w−1].
  - KSUB8/KSUB16: saturating subtract, same clamps.
  - SLL8/SLL16: logical left shift of every lane. Amount = operand_b_i[2:0] (w=8) or [3:0] (w=16).
  - SRL8/SRL16: right shift, same amount field. Arithmetic if signed, logical if unsigned.
  - CMPEQ8/CMPEQ16: lane = all-ones if a==b, else 0.
  - SLT8/SLT16: lane = all-ones if a<b (signed or unsigned compare), else 0.
  - ZUNPKD8xy, for xy ∈ {10,20,30,31,32}: result = {zext16(byte x of A), zext16(byte y of A)}. Operand B and signedness are ignored.
  - SUNPKD8xy: same byte selection, sign-extended to 16 bits.
- Undefined operator_i encodings: the combinational result is 0. It is still registered when enable_i=1.

Decomposition:
- Package ibex_pkg_pext holds:
  - signed_type_e {S8, U8, S16, U16};
  - zpn_op_e, covering every operation above (ZPN_ADD8 … ZPN_ZUNPKD810 … ZPN_SUNPKD832);
  - lane-count constants.
- One natural sub-module, ibex_pext_lane16: a 16-bit lane adder/saturator usable as two 8-bit lanes. It takes a split control and signed/sat/halve/sub flags, and is instantiated twice.
- Shift, compare and unpack logic stay in the top module.

Test Plan:
- Reset/unpack:
  - Hold rst_ni=0 → result_o=0x00000000.
  - Release reset; apply A=0x81267F83, B=0x00000002, ZUNPKD810, U16, enable=1 → result_o=0x007F0083 after the next edge.
  - Switch to SUNPKD810 → 0x007FFF83.
  - ZUNPKD832 with the same A → 0x00810026.
- Add/saturate:
  - A=0x7FFF0001, B=0x00010001, ADD16 → 0x80000002.
  - KADD16 S16 → 0x7FFF0002.
  - A=0xFFFF0001, B=0x00020001, KADD16 U16 → 0xFFFF0002.
- Subtract/halving:
  - A=0x00000000, B=0x01010101, SUB8 → 0xFFFFFFFF.
  - A=0x7F7F7F7F, B=0x01010101, RADD8 S8 → 0x40404040.
  - A=0xFFFFFFFF, B=0x01010101, RADD8 U8 → 0x80808080.
- Shifts:
  - A=0x80000010, B=0x00000002, SRL16 S16 → 0xE0000004.
  - Same with U16 → 0x20000004.
  - SLL16 → 0x00000040.
  - B=0x12 with SLL16 uses amount 2 → 0x00000040.
- Compare:
  - A=0x05FF0300, B=0x05010300, CMPEQ8 → 0xFF00FFFF.
  - SLT8 S8 → 0x00FF0000.
  - SLT8 U8 → 0x00000000.
- Hold/reset mid-op:
  - enable=0 while operands change → result_o unchanged.
  - Assert rst_ni low between edges → result_o goes to 0 immediately, without waiting for a clock edge.
